// File: rtl/idu_is_pipe3_sched_if.sv
// Dispatch and issue bundle for the pipe3 issue queue.
// The master drives dispatch and consumes issue; the slave is the scheduler.
interface idu_is_pipe3_sched_if;
  logic        dis_vld;
  logic        dis_rdy;
  logic [4:0]  dis_iid;
  logic [6:0]  dis_opcode;
  logic [6:0]  dis_funct7;
  logic [2:0]  dis_funct3;
  logic [63:0] dis_pc;
  logic        dis_psrc1_vld;
  logic [5:0]  dis_psrc1;
  logic        dis_psrc1_rdy;
  logic        dis_psrc2_vld;
  logic [5:0]  dis_psrc2;
  logic        dis_psrc2_rdy;
  logic        dis_pdst_vld;
  logic [5:0]  dis_pdst;
  logic        dis_imm_vld;
  logic [63:0] dis_imm;

  logic        idu_idu_rf_pipe3_vld;
  logic [4:0]  idu_idu_rf_pipe3_iid;
  logic [6:0]  idu_idu_rf_pipe3_opcode;
  logic [6:0]  idu_idu_rf_pipe3_funct7;
  logic [2:0]  idu_idu_rf_pipe3_funct3;
  logic [63:0] idu_idu_rf_pipe3_pc;
  logic        idu_idu_rf_pipe3_psrc1_vld;
  logic [5:0]  idu_idu_rf_pipe3_psrc1;
  logic        idu_idu_rf_pipe3_psrc2_vld;
  logic [5:0]  idu_idu_rf_pipe3_psrc2;
  logic        idu_idu_rf_pipe3_pdst_vld;
  logic [5:0]  idu_idu_rf_pipe3_pdst;
  logic        idu_idu_rf_pipe3_imm_vld;
  logic [63:0] idu_idu_rf_pipe3_imm;

  modport master (
    output dis_vld, dis_iid, dis_opcode, dis_funct7, dis_funct3,
    output dis_pc, dis_psrc1_vld, dis_psrc1, dis_psrc1_rdy,
    output dis_psrc2_vld, dis_psrc2, dis_psrc2_rdy,
    output dis_pdst_vld, dis_pdst, dis_imm_vld, dis_imm,
    input  dis_rdy,
    input  idu_idu_rf_pipe3_vld, idu_idu_rf_pipe3_iid,
    input  idu_idu_rf_pipe3_opcode, idu_idu_rf_pipe3_funct7,
    input  idu_idu_rf_pipe3_funct3, idu_idu_rf_pipe3_pc,
    input  idu_idu_rf_pipe3_psrc1_vld, idu_idu_rf_pipe3_psrc1,
    input  idu_idu_rf_pipe3_psrc2_vld, idu_idu_rf_pipe3_psrc2,
    input  idu_idu_rf_pipe3_pdst_vld, idu_idu_rf_pipe3_pdst,
    input  idu_idu_rf_pipe3_imm_vld, idu_idu_rf_pipe3_imm
  );

  modport slave (
    input  dis_vld, dis_iid, dis_opcode, dis_funct7, dis_funct3,
    input  dis_pc, dis_psrc1_vld, dis_psrc1, dis_psrc1_rdy,
    input  dis_psrc2_vld, dis_psrc2, dis_psrc2_rdy,
    input  dis_pdst_vld, dis_pdst, dis_imm_vld, dis_imm,
    output dis_rdy,
    output idu_idu_rf_pipe3_vld, idu_idu_rf_pipe3_iid,
    output idu_idu_rf_pipe3_opcode, idu_idu_rf_pipe3_funct7,
    output idu_idu_rf_pipe3_funct3, idu_idu_rf_pipe3_pc,
    output idu_idu_rf_pipe3_psrc1_vld, idu_idu_rf_pipe3_psrc1,
    output idu_idu_rf_pipe3_psrc2_vld, idu_idu_rf_pipe3_psrc2,
    output idu_idu_rf_pipe3_pdst_vld, idu_idu_rf_pipe3_pdst,
    output idu_idu_rf_pipe3_imm_vld, idu_idu_rf_pipe3_imm
  );
endinterface

// File: rtl/idu_is_pipe3_sched.sv
// Four-entry pipe3 issue queue: wakeup tracking and oldest-ready select.
// Age is kept as a pairwise older-than matrix so it survives frees.
module idu_is_pipe3_sched (
  input  logic        clk,
  input  logic        rst_clk,
  input  logic        rtu_global_flush,
  input  logic [3:0]  exu_idu_is_wake_vld,
  input  logic [23:0] exu_idu_is_wake_preg,
  input  logic        exu_idu_is_pipe3_stall,
  output logic [2:0]  is_entry_cnt,
  idu_is_pipe3_sched_if.slave pipe_if
);

  typedef struct packed {
    logic [4:0]  iid;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [63:0] pc;
    logic        psrc1_vld;
    logic [5:0]  psrc1;
    logic        psrc2_vld;
    logic [5:0]  psrc2;
    logic        pdst_vld;
    logic [5:0]  pdst;
    logic        imm_vld;
    logic [63:0] imm;
  } ent_t;

  ent_t       ent_q [4];
  logic [3:0] vld_q;
  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] older_q [4];
  logic [2:0] cnt_q;

  ent_t       dis_ent;
  ent_t       sel_ent;
  ent_t       out_ent;
  logic [3:0] rdy;
  logic [3:0] blk;
  logic [3:0] sel;
  logic [3:0] iss_oh;
  logic [3:0] wr_oh;
  logic [3:0] wk1;
  logic [3:0] wk2;
  logic       iss;
  logic       acc;
  logic       d_s1;
  logic       d_s2;

  function automatic logic wake_hit(
    input logic [3:0]  v,
    input logic [23:0] p,
    input logic [5:0]  tag
  );
    logic h;
    h = 1'b0;
    for (int k = 0; k < 4; k++)
      if (v[k] && p[6*k +: 6] == tag) h = 1'b1;
    return h;
  endfunction

  assign dis_ent = '{
    iid:       pipe_if.dis_iid,
    opcode:    pipe_if.dis_opcode,
    funct7:    pipe_if.dis_funct7,
    funct3:    pipe_if.dis_funct3,
    pc:        pipe_if.dis_pc,
    psrc1_vld: pipe_if.dis_psrc1_vld,
    psrc1:     pipe_if.dis_psrc1,
    psrc2_vld: pipe_if.dis_psrc2_vld,
    psrc2:     pipe_if.dis_psrc2,
    pdst_vld:  pipe_if.dis_pdst_vld,
    pdst:      pipe_if.dis_pdst,
    imm_vld:   pipe_if.dis_imm_vld,
    imm:       pipe_if.dis_imm
  };

  assign pipe_if.dis_rdy = (cnt_q < 3'd4) & ~rtu_global_flush;
  assign acc = pipe_if.dis_vld & pipe_if.dis_rdy;

  assign d_s1 = ~dis_ent.psrc1_vld | pipe_if.dis_psrc1_rdy
    | wake_hit(exu_idu_is_wake_vld, exu_idu_is_wake_preg, dis_ent.psrc1);
  assign d_s2 = ~dis_ent.psrc2_vld | pipe_if.dis_psrc2_rdy
    | wake_hit(exu_idu_is_wake_vld, exu_idu_is_wake_preg, dis_ent.psrc2);

  always_comb begin
    wk1 = '0;
    wk2 = '0;
    for (int i = 0; i < 4; i++) begin
      wk1[i] = ent_q[i].psrc1_vld & wake_hit(exu_idu_is_wake_vld,
        exu_idu_is_wake_preg, ent_q[i].psrc1);
      wk2[i] = ent_q[i].psrc2_vld & wake_hit(exu_idu_is_wake_vld,
        exu_idu_is_wake_preg, ent_q[i].psrc2);
    end
  end

  assign rdy = vld_q & s1_q & s2_q;

  // An entry is blocked if any older entry is also ready.
  always_comb begin
    blk = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (j != i && rdy[j] && older_q[j][i]) blk[i] = 1'b1;
  end

  assign sel = rdy & ~blk;
  assign iss = (|rdy) & ~exu_idu_is_pipe3_stall
    & ~rtu_global_flush & ~rst_clk;
  assign iss_oh = sel & {4{iss}};

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < 4; i++)
      if (sel[i]) sel_ent = sel_ent | ent_q[i];
  end

  assign out_ent = iss ? sel_ent : '0;

  always_comb begin
    wr_oh = '0;
    for (int i = 3; i >= 0; i--)
      if (!vld_q[i]) begin
        wr_oh = '0;
        wr_oh[i] = 1'b1;
      end
    if (!acc) wr_oh = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_oh[i]) ent_q[i] <= dis_ent;
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) older_q[i] <= '0;
    end else if (rtu_global_flush) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_oh[i]) begin
          vld_q[i]   <= 1'b1;
          s1_q[i]    <= d_s1;
          s2_q[i]    <= d_s2;
          older_q[i] <= '0;
        end else begin
          if (iss_oh[i]) vld_q[i] <= 1'b0;
          s1_q[i] <= s1_q[i] | wk1[i];
          s2_q[i] <= s2_q[i] | wk2[i];
        end
      end
      // Every entry present at write time is older than the new one.
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (wr_oh[j] && i != j) older_q[i][j] <= vld_q[i];
      cnt_q <= cnt_q + {2'b0, acc} - {2'b0, iss};
    end
  end

  assign is_entry_cnt = cnt_q;

  assign pipe_if.idu_idu_rf_pipe3_vld       = iss;
  assign pipe_if.idu_idu_rf_pipe3_iid       = out_ent.iid;
  assign pipe_if.idu_idu_rf_pipe3_opcode    = out_ent.opcode;
  assign pipe_if.idu_idu_rf_pipe3_funct7    = out_ent.funct7;
  assign pipe_if.idu_idu_rf_pipe3_funct3    = out_ent.funct3;
  assign pipe_if.idu_idu_rf_pipe3_pc        = out_ent.pc;
  assign pipe_if.idu_idu_rf_pipe3_psrc1_vld = out_ent.psrc1_vld;
  assign pipe_if.idu_idu_rf_pipe3_psrc1     = out_ent.psrc1;
  assign pipe_if.idu_idu_rf_pipe3_psrc2_vld = out_ent.psrc2_vld;
  assign pipe_if.idu_idu_rf_pipe3_psrc2     = out_ent.psrc2;
  assign pipe_if.idu_idu_rf_pipe3_pdst_vld  = out_ent.pdst_vld;
  assign pipe_if.idu_idu_rf_pipe3_pdst      = out_ent.pdst;
  assign pipe_if.idu_idu_rf_pipe3_imm_vld   = out_ent.imm_vld;
  assign pipe_if.idu_idu_rf_pipe3_imm       = out_ent.imm;

endmodule

// File: tb/tb_idu_is_pipe3_sched.sv
// Bench for idu_is_pipe3_sched: directed cases plus random traffic
// checked every cycle against an in-order queue reference model.
module tb_idu_is_pipe3_sched;

  logic        clk = 1'b0;
  logic        rst_clk;
  logic        rtu_global_flush;
  logic [3:0]  wake_vld;
  logic [23:0] wake_preg;
  logic        stall;
  logic [2:0]  cnt;

  idu_is_pipe3_sched_if bus ();

  idu_is_pipe3_sched dut (
    .clk                    (clk),
    .rst_clk                (rst_clk),
    .rtu_global_flush       (rtu_global_flush),
    .exu_idu_is_wake_vld    (wake_vld),
    .exu_idu_is_wake_preg   (wake_preg),
    .exu_idu_is_pipe3_stall (stall),
    .is_entry_cnt           (cnt),
    .pipe_if                (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [171:0] pay;
    logic         p1v;
    logic [5:0]   p1;
    logic         p2v;
    logic [5:0]   p2;
    logic         s1;
    logic         s2;
  } m_t;

  m_t q[$];
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [171:0] obs,
                     input logic [171:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input logic [5:0] p);
    for (int k = 0; k < 4; k++)
      if (wake_vld[k] && wake_preg[6*k +: 6] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [171:0] dis_pay();
    return {bus.dis_iid, bus.dis_opcode, bus.dis_funct7, bus.dis_funct3,
            bus.dis_pc, bus.dis_psrc1_vld, bus.dis_psrc1,
            bus.dis_psrc2_vld, bus.dis_psrc2, bus.dis_pdst_vld,
            bus.dis_pdst, bus.dis_imm_vld, bus.dis_imm};
  endfunction

  function automatic logic [171:0] out_pay();
    return {bus.idu_idu_rf_pipe3_iid, bus.idu_idu_rf_pipe3_opcode,
            bus.idu_idu_rf_pipe3_funct7, bus.idu_idu_rf_pipe3_funct3,
            bus.idu_idu_rf_pipe3_pc, bus.idu_idu_rf_pipe3_psrc1_vld,
            bus.idu_idu_rf_pipe3_psrc1, bus.idu_idu_rf_pipe3_psrc2_vld,
            bus.idu_idu_rf_pipe3_psrc2, bus.idu_idu_rf_pipe3_pdst_vld,
            bus.idu_idu_rf_pipe3_pdst, bus.idu_idu_rf_pipe3_imm_vld,
            bus.idu_idu_rf_pipe3_imm};
  endfunction

  task automatic idle();
    rst_clk = 1'b0;
    rtu_global_flush = 1'b0;
    wake_vld = '0;
    wake_preg = '0;
    bus.dis_vld = 1'b0;
    bus.dis_psrc1_vld = 1'b0;
    bus.dis_psrc2_vld = 1'b0;
    bus.dis_psrc1_rdy = 1'b0;
    bus.dis_psrc2_rdy = 1'b0;
  endtask

  task automatic rnd_payload();
    bus.dis_iid    = 5'($urandom);
    bus.dis_opcode = 7'($urandom);
    bus.dis_funct7 = 7'($urandom);
    bus.dis_funct3 = 3'($urandom);
    bus.dis_pc     = {$urandom, $urandom};
    bus.dis_pdst_vld = 1'($urandom);
    bus.dis_pdst   = 6'($urandom);
    bus.dis_imm_vld = 1'($urandom);
    bus.dis_imm    = {$urandom, $urandom};
  endtask

  task automatic dis(input logic [4:0] iid, input logic p1v,
                     input logic [5:0] p1, input logic p1r,
                     input logic p2v, input logic [5:0] p2,
                     input logic p2r);
    rnd_payload();
    bus.dis_vld = 1'b1;
    bus.dis_iid = iid;
    bus.dis_psrc1_vld = p1v;
    bus.dis_psrc1 = p1;
    bus.dis_psrc1_rdy = p1r;
    bus.dis_psrc2_vld = p2v;
    bus.dis_psrc2 = p2;
    bus.dis_psrc2_rdy = p2r;
  endtask

  // Check this cycle's outputs, then advance the model across the edge.
  task automatic step();
    int sel;
    logic e_rdy, e_vld;
    logic [171:0] e_pay;
    m_t n;
    #2;
    sel = -1;
    foreach (q[i])
      if (sel < 0 && q[i].s1 && q[i].s2) sel = i;
    e_rdy = (q.size() < 4) && !rtu_global_flush;
    e_vld = (sel >= 0) && !stall && !rtu_global_flush && !rst_clk;
    e_pay = e_vld ? q[sel].pay : '0;
    if (chk_en) begin
      chk("cnt", 172'(cnt), 172'(q.size()));
      chk("dis_rdy", 172'(bus.dis_rdy), 172'(e_rdy));
      chk("vld", 172'(bus.idu_idu_rf_pipe3_vld), 172'(e_vld));
      chk("iid", 172'(bus.idu_idu_rf_pipe3_iid), 172'(e_pay[171:167]));
      chk("payload", out_pay(), e_pay);
    end
    if (rst_clk || rtu_global_flush) begin
      q.delete();
    end else begin
      foreach (q[i]) begin
        if (q[i].p1v && hit(q[i].p1)) q[i].s1 = 1'b1;
        if (q[i].p2v && hit(q[i].p2)) q[i].s2 = 1'b1;
      end
      if (e_vld) q.delete(sel);
      if (bus.dis_vld && e_rdy) begin
        n.pay = dis_pay();
        n.p1v = bus.dis_psrc1_vld;
        n.p1  = bus.dis_psrc1;
        n.p2v = bus.dis_psrc2_vld;
        n.p2  = bus.dis_psrc2;
        n.s1  = !n.p1v || bus.dis_psrc1_rdy || hit(n.p1);
        n.s2  = !n.p2v || bus.dis_psrc2_rdy || hit(n.p2);
        q.push_back(n);
      end
    end
    @(negedge clk);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      step();
    end
  endtask

  initial begin
    stall = 1'b0;
    idle();
    rnd_payload();
    @(negedge clk);
    rst_clk = 1'b1;
    bus.dis_vld = 1'b1;
    step();
    chk_en = 1'b1;
    rst_clk = 1'b1;
    bus.dis_vld = 1'b1;
    step();
    idles(1);

    dis(5'd3, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    step();
    idles(2);

    dis(5'd5, 1'b1, 6'd12, 1'b0, 1'b0, 6'd0, 1'b0);
    step();
    idles(2);
    wake_vld = 4'b0100;
    wake_preg = 24'd12 << 12;
    step();
    idles(2);

    dis(5'd1, 1'b1, 6'd7, 1'b0, 1'b0, 6'd0, 1'b0);
    step();
    dis(5'd2, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    step();
    idles(2);
    wake_vld = 4'b0001;
    wake_preg = 24'd7;
    step();
    idles(2);
    dis(5'd1, 1'b1, 6'd7, 1'b0, 1'b0, 6'd0, 1'b0);
    step();
    dis(5'd2, 1'b1, 6'd7, 1'b0, 1'b0, 6'd0, 1'b0);
    step();
    idle();
    wake_vld = 4'b1000;
    wake_preg = 24'd7 << 18;
    step();
    idles(3);

    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dis(5'(10 + i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      step();
    end
    stall = 1'b0;
    idles(5);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dis(5'(20 + i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      step();
    end
    stall = 1'b0;
    dis(5'd30, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    rtu_global_flush = 1'b1;
    step();
    idles(2);

    for (int c = 0; c < 3000; c++) begin
      idle();
      rnd_payload();
      bus.dis_vld = ($urandom_range(0, 9) < 6);
      bus.dis_psrc1_vld = 1'($urandom);
      bus.dis_psrc1 = 6'($urandom_range(0, 7));
      bus.dis_psrc1_rdy = ($urandom_range(0, 3) == 0);
      bus.dis_psrc2_vld = 1'($urandom);
      bus.dis_psrc2 = 6'($urandom_range(0, 7));
      bus.dis_psrc2_rdy = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) begin
        wake_vld[k] = ($urandom_range(0, 3) == 0);
        wake_preg[6*k +: 6] = 6'($urandom_range(0, 7));
      end
      stall = ($urandom_range(0, 9) < 2);
      rtu_global_flush = ($urandom_range(0, 99) < 3);
      rst_clk = ($urandom_range(0, 99) < 2);
      step();
    end
    stall = 1'b0;
    idles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idu_is_pipe3_sched.md
IDU_IS_PIPE3_SCHED -- requirements
Module: idu_is_pipe3_sched

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_clk  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: rtu_global_flush  in  1  discard all queued instructions.
REQ-004 SHALL have ports: dis_vld in 1, dis_rdy out 1  dispatch valid/ready handshake.
REQ-005 SHALL have ports: dis_iid in 5, dis_opcode in 7, dis_funct7 in 7, dis_funct3 in 3, dis_pc in 64  instruction payload.
REQ-006 SHALL have ports: dis_psrc1_vld in 1, dis_psrc1 in 6, dis_psrc1_rdy in 1; same for psrc2  sources and operand readiness at dispatch.
REQ-007 SHALL have ports: dis_pdst_vld in 1, dis_pdst in 6, dis_imm_vld in 1, dis_imm in 64  destination and immediate.
REQ-008 SHALL have ports: exu_idu_is_wake_vld in 4, exu_idu_is_wake_preg in 24  four wakeup ports, port k on preg bits [6k+5:6k].
REQ-009 SHALL have ports: exu_idu_is_pipe3_stall in 1  downstream holds issue.
REQ-010 SHALL have ports: idu_idu_rf_pipe3_vld out 1 plus every idu_idu_rf_pipe3_* payload output, widths equal to the matching dis_* field (psrc*_rdy excluded).
REQ-011 SHALL have ports: is_entry_cnt out 3  occupied entries, 0..4.

Function
REQ-012 SHALL hold 4 entries; each stores full payload, valid bit, src1_rdy, src2_rdy, dispatch age.
REQ-013 dis_rdy SHALL equal (is_entry_cnt < 4) & ~rtu_global_flush; purely from registered count, no same-cycle reuse of issuing entry.
REQ-014 Dispatch accepted when dis_vld & dis_rdy; written into lowest-index free entry at the rising edge.
REQ-015 Entry srcN_rdy at write SHALL be ~dis_psrcN_vld | dis_psrcN_rdy | (any wake port valid with preg == dis_psrcN) in the dispatch cycle.
REQ-016 Each cycle, any valid entry with srcN_vld & ~srcN_rdy SHALL set srcN_rdy at the edge if any wake port valid matches its psrcN.
REQ-017 Ready entry = valid & src1_rdy & src2_rdy, from registered bits only (wakeup visible to select one cycle later).
REQ-018 Select SHALL pick the oldest ready entry by dispatch order; ties impossible.
REQ-019 idu_idu_rf_pipe3_vld SHALL be combinational: (any ready entry) & ~exu_idu_is_pipe3_stall & ~rtu_global_flush & ~rst_clk.
REQ-020 When vld=1 payload outputs SHALL be the selected entry's fields; when vld=0 all payload outputs SHALL be 0.
REQ-021 Issued entry freed at the edge ending the issue cycle; stall keeps all entries and age order unchanged.
REQ-022 Minimum latency: dispatch with ready sources in cycle N -> issue in cycle N+1.
REQ-023 is_entry_cnt next = cnt + accept - issue; simultaneous accept and issue leaves count unchanged.
REQ-024 Age order SHALL persist across frees; a younger entry never issues ahead of an older ready one.
REQ-025 rtu_global_flush SHALL invalidate all entries at the edge; dispatch in the flush cycle dropped; count becomes 0.

Reset
REQ-026 rst_clk=1 at a rising edge SHALL clear all entry valid/ready bits, ages, and count; dominates flush and dispatch.
REQ-027 After reset: is_entry_cnt=0, dis_rdy=1, idu_idu_rf_pipe3_vld=0, all payload outputs 0.
REQ-028 Reset asserted mid-operation SHALL drop all queued instructions with no issue in that cycle.

Verification
REQ-029 Reset: rst_clk=1 two cycles with dis_vld=1 -> cnt=0, vld=0, no entry captured.
REQ-030 Ready dispatch: cycle 0 dis iid=3, both psrc_vld=0 -> cycle 1 vld=1 iid=3; cycle 2 cnt=0, vld=0.
REQ-031 Wakeup: dispatch iid=5 psrc1=12 not ready; cycle 3 wake port 2 preg=12 -> vld=1 iid=5 in cycle 4, not earlier.
REQ-032 Age: iid=1 (psrc1=7 not ready) then iid=2 ready; wake 7 after iid=2 issues -> issue order 2 then 1; both ready simultaneously -> 1 first.
REQ-033 Full/stall: stall=1, dispatch 4 ready entries -> cnt=4, dis_rdy=0, vld=0; release stall -> iids in dispatch order, dis_rdy=1 cycle after first issue.
REQ-034 Flush: 3 entries queued, flush with dis_vld=1 -> vld=0 that cycle, next cycle cnt=0, dispatched instruction absent.
